range_sweep_ctrl: RTL and testbench
===================================

# range_sweep_ctrl

Synthesizable sweep sequencer that generates a programmable arithmetic value sequence (start..stop inclusive by step, or the full 0..2^W-1 range) and presents each value on a valid/ready stream, with an optional dwell gap between values. It replaces testbench-side looping for self-checking benches and on-chip exercisers. It sits in front of a DUT input or a shared stimulus bus, and is started, monitored and aborted by a host FSM.

## Interface
- W, 8: value width in bits (1..31)
- DWELL_W, 8: width of dwell counter
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- go  in  1  start pulse; config sampled on the same cycle
- abort  in  1  terminate sweep; has priority over all other inputs except reset
- cfg_full  in  1  1 = full range (start=0, stop=2^W-1, step=1); cfg_start, cfg_stop and cfg_step are ignored
- cfg_start  in  W  first value
- cfg_stop  in  W  last value bound (inclusive)
- cfg_step  in  W  increment (unsigned, non-zero)
- cfg_dwell  in  DWELL_W  idle cycles inserted after each accepted beat
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- out_data  out  W  current sweep value
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at normal completion
- cfg_err  out  1  one-cycle pulse when go is rejected
- beat_cnt  out  W+1  beats accepted since the last accepted go

## Operation
- States: IDLE, DRIVE, DWELL, DONE.
- IDLE:
  - go with a valid config: latch start, stop, step and dwell; load cur=start; clear beat_cnt; go to DRIVE.
  - Invalid config (only when cfg_full=0): step==0 or start>stop. Response: pulse cfg_err, stay in IDLE, leave beat_cnt unchanged.
- DRIVE: out_valid=1, out_data=cur. On out_valid&out_ready, beat_cnt increments, then:
  - Compute nxt=cur+step in W+1 bits.
  - last = (nxt>stop) or nxt[W]. The carry bit covers wrap-around at 2^W-1.
  - If dwell>0: load the dwell counter with dwell and go to DWELL.
  - Else if last: go to DONE. Otherwise cur=nxt and stay in DRIVE.
- DWELL: out_valid=0. The counter decrements each cycle. At counter==1: go to DONE if last, otherwise go to DRIVE with cur=nxt. The last flag is registered at the handshake.
- DONE: done=1 for exactly one cycle, then IDLE.
- go is ignored outside IDLE, including in DONE.
- abort in any non-IDLE state: go to IDLE next cycle, with no done pulse. out_valid drops at the next edge. beat_cnt holds its value.
- abort and go together in IDLE: abort wins; go is ignored, with no cfg_err.
- out_data and out_valid hold stable while out_valid=1 and out_ready=0 (stream rule). out_valid never drops without a handshake except on abort or reset.
- busy=1 in DRIVE, DWELL and DONE.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, out_valid=0, out_data=0, busy=0, done=0, cfg_err=0, beat_cnt=0, internal cur, stop, step and dwell registers=0.
- go accepted at edge N: out_valid=1 and out_data=start from cycle N+1. cfg_err is asserted in cycle N+1 on rejection.
- Handshake at edge T with dwell=0, not last: next value is valid in cycle T+1. With ready held high, throughput is 1 beat/cycle.
- Handshake at edge T with dwell=D>0: out_valid=0 for cycles T+1..T+D, next value valid in cycle T+D+1.
- Last handshake at edge T: done=1 in cycle T+1+D, busy=0 from cycle T+2+D.
- Total beats for a valid sweep = floor((stop-start)/step)+1. Full range gives 2^W beats; beat_cnt reaches 2^W without overflow.
- All outputs are registered. out_ready has no combinational path to out_valid.

## Test plan
- W=8, start=3, stop=20, step=5, dwell=0, ready=1: beats 3, 8, 13, 18 on consecutive cycles. done pulses one cycle after beat 18. beat_cnt=4.
- W=4, cfg_full=1, dwell=2, ready=1: beats 0..15 each followed by 2 invalid cycles. No wrap to 0 after 15. beat_cnt=16. done in cycle 3 after the beat-15 handshake.
- W=8, start=250, stop=255, step=4: beats 250, 254 only. The carry/overflow compare terminates the sweep. done follows.
- Backpressure: start=0, stop=2, step=1, ready pattern 0,0,1,0,1,1. out_data holds 0 through both stalls. Sequence 0, 1, 2 accepted with no duplicates or drops.
- Invalid go: step=0 or start=9 with stop=4. cfg_err pulses one cycle, busy stays 0, no out_valid. A second go issued during an active sweep is ignored.
- Abort: abort after beat 2 of the 0..10 sweep, and separately rst_n=0 mid-DWELL. Abort: out_valid=0 next cycle, no done, beat_cnt=2. Reset: all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/range_sweep_ctrl.sv
// Programmable arithmetic sweep generator: emits start..stop by step (or the
// full 0..2^W-1 range) on a valid/ready stream with an optional dwell gap.
module range_sweep_ctrl #(
  parameter int W       = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               abort,
  input  logic               cfg_full,
  input  logic [W-1:0]       cfg_start,
  input  logic [W-1:0]       cfg_stop,
  input  logic [W-1:0]       cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [W:0]         beat_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, DWELL, DONE} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [W-1:0]       r_cur;
  logic [W-1:0]       r_stop;
  logic [W-1:0]       r_step;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_dwellCnt;
  logic               r_last;
  logic [W:0]         r_beatCnt;
  logic               r_outValid;
  logic               r_busy;
  logic               r_done;
  logic               r_cfgErr;

  logic               w_cfgValid;
  logic               w_hs;
  logic [W:0]         w_nxt;
  logic               w_last;
  logic               w_dwellEnd;
  logic               w_outValid;
  logic               w_busy;
  logic               w_done;
  logic               w_cfgErr;

  // The extra carry bit of w_nxt catches sweeps that would wrap past 2^W-1.
  assign w_cfgValid = cfg_full | ((cfg_step != '0) && (cfg_start <= cfg_stop));
  assign w_hs       = (r_state == DRIVE) && out_ready;
  assign w_nxt      = {1'b0, r_cur} + {1'b0, r_step};
  assign w_last     = w_nxt[W] || (w_nxt > {1'b0, r_stop});
  assign w_dwellEnd = (r_dwellCnt == DWELL_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (!abort && go && w_cfgValid) w_nextState = DRIVE;
      end
      DRIVE: begin
        if (abort) begin
          w_nextState = IDLE;
        end else if (w_hs) begin
          if (r_dwell != '0)  w_nextState = DWELL;
          else if (w_last)    w_nextState = DONE;
          else                w_nextState = DRIVE;
        end
      end
      DWELL: begin
        if (abort)           w_nextState = IDLE;
        else if (w_dwellEnd) w_nextState = r_last ? DONE : DRIVE;
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the block registered.
  always_comb begin
    w_outValid = (w_nextState == DRIVE);
    w_busy     = (w_nextState != IDLE);
    w_done     = (w_nextState == DONE);
    w_cfgErr   = (r_state == IDLE) && go && !abort && !w_cfgValid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cfgErr   <= 1'b0;
    end else begin
      r_outValid <= w_outValid;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_cfgErr   <= w_cfgErr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cur      <= '0;
      r_stop     <= '0;
      r_step     <= '0;
      r_dwell    <= '0;
      r_dwellCnt <= '0;
      r_last     <= 1'b0;
      r_beatCnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (go && !abort && w_cfgValid) begin
            if (cfg_full) begin
              r_cur  <= '0;
              r_stop <= '1;
              r_step <= W'(1);
            end else begin
              r_cur  <= cfg_start;
              r_stop <= cfg_stop;
              r_step <= cfg_step;
            end
            r_dwell   <= cfg_dwell;
            r_beatCnt <= '0;
          end
        end
        DRIVE: begin
          if (!abort && w_hs) begin
            r_beatCnt <= r_beatCnt + (W+1)'(1);
            if (r_dwell != '0) begin
              r_dwellCnt <= r_dwell;
              r_last     <= w_last;
            end else if (!w_last) begin
              r_cur <= w_nxt[W-1:0];
            end
          end
        end
        DWELL: begin
          if (!abort) begin
            r_dwellCnt <= r_dwellCnt - DWELL_W'(1);
            if (w_dwellEnd && !r_last) r_cur <= w_nxt[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_cur;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cfg_err   = r_cfgErr;
  assign beat_cnt  = r_beatCnt;

endmodule

// File: tb/tb_range_sweep_ctrl.sv
// Randomized bench for range_sweep_ctrl; expected beats come from a queue built
// directly from the start/stop/step arithmetic, with timing tracked per phase.
module tb_range_sweep_ctrl;

  localparam int W  = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          go;
  logic          abort;
  logic          cfg_full;
  logic [W-1:0]  cfg_start;
  logic [W-1:0]  cfg_stop;
  logic [W-1:0]  cfg_step;
  logic [DW-1:0] cfg_dwell;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [W:0]    beat_cnt;

  int vecCount  = 0;
  int errCount  = 0;
  int lastBeats = 0;
  bit readyPat[$];

  range_sweep_ctrl #(.W(W), .DWELL_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .abort     (abort),
    .cfg_full  (cfg_full),
    .cfg_start (cfg_start),
    .cfg_stop  (cfg_stop),
    .cfg_step  (cfg_step),
    .cfg_dwell (cfg_dwell),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".valid"}, out_valid, 0);
    checkOutput({tag, ".busy"}, busy, 0);
    checkOutput({tag, ".done"}, done, 0);
  endtask

  // Runs one sweep; the reference is the explicit list of expected values.
  task automatic applyStimulus(input bit full, input int s, input int e, input int st,
                               input int d, input int readyPct, input int abortAt,
                               input bit junkGo);
    int expQ[$];
    int total;
    int mode;
    int gap;
    int beats;
    int cycles;
    bit rdy;
    bit finished;
    if (full) begin
      for (int v = 0; v < (1 << W); v++) expQ.push_back(v);
    end else begin
      for (int v = s; v <= e; v += st) expQ.push_back(v);
    end
    total     = expQ.size();
    go        = 1'b1;
    abort     = 1'b0;
    cfg_full  = full;
    cfg_start = W'(s);
    cfg_stop  = W'(e);
    cfg_step  = W'(st);
    cfg_dwell = DW'(d);
    out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    mode     = 0;
    gap      = 0;
    beats    = 0;
    cycles   = 0;
    finished = 1'b0;
    while (!finished && cycles < 20000) begin
      go    = 1'b0;
      abort = 1'b0;
      checkOutput("cfgErrQuiet", cfg_err, 0);
      case (mode)
        0: begin
          checkOutput("driveValid", out_valid, 1);
          checkOutput("driveData", out_data, expQ[0]);
          checkOutput("driveBusy", busy, 1);
          if (abortAt >= 0 && beats == abortAt) begin
            abort     = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            mode      = 4;
          end else begin
            if (readyPat.size() > 0) rdy = readyPat.pop_front();
            else rdy = ($urandom_range(1, 100) <= readyPct);
            out_ready = rdy;
            if (rdy) begin
              void'(expQ.pop_front());
              beats++;
              if (d > 0) begin
                gap  = d;
                mode = 1;
              end else begin
                mode = (expQ.size() == 0) ? 2 : 0;
              end
            end
          end
        end
        1: begin
          checkOutput("dwellValid", out_valid, 0);
          checkOutput("dwellBusy", busy, 1);
          out_ready = 1'($urandom_range(0, 1));
          gap--;
          if (gap == 0) mode = (expQ.size() == 0) ? 2 : 0;
        end
        2: begin
          checkOutput("donePulse", done, 1);
          checkOutput("doneValid", out_valid, 0);
          checkOutput("doneBusy", busy, 1);
          mode = 3;
        end
        3: begin
          checkIdle("afterDone");
          checkOutput("finalBeats", beat_cnt, total);
          lastBeats = total;
          finished  = 1'b1;
        end
        default: begin
          checkIdle("afterAbort");
          checkOutput("abortBeats", beat_cnt, abortAt);
          lastBeats = abortAt;
          finished  = 1'b1;
        end
      endcase
      if (junkGo && !finished && !abort && mode != 3 && mode != 4) begin
        go        = 1'($urandom_range(0, 1));
        cfg_full  = 1'($urandom_range(0, 1));
        cfg_start = W'($urandom);
        cfg_stop  = W'($urandom);
        cfg_step  = W'($urandom_range(0, 3));
      end
      @(negedge clk);
      cycles++;
    end
    checkOutput("sweepTimeout", finished, 1);
    go    = 1'b0;
    abort = 1'b0;
    readyPat.delete();
  endtask

  task automatic badGo(input int s, input int e, input int st);
    go        = 1'b1;
    cfg_full  = 1'b0;
    cfg_start = W'(s);
    cfg_stop  = W'(e);
    cfg_step  = W'(st);
    @(negedge clk);
    go = 1'b0;
    checkOutput("badGoErr", cfg_err, 1);
    checkIdle("badGo");
    @(negedge clk);
    checkOutput("badGoErrPulse", cfg_err, 0);
    checkOutput("badGoBeats", beat_cnt, lastBeats);
    checkIdle("badGoAfter");
  endtask

  task automatic abortWithGo(input bit validCfg);
    go        = 1'b1;
    abort     = 1'b1;
    cfg_full  = 1'b0;
    cfg_start = validCfg ? W'(1) : W'(9);
    cfg_stop  = W'(4);
    cfg_step  = W'(1);
    @(negedge clk);
    go    = 1'b0;
    abort = 1'b0;
    checkIdle("abortGo");
    checkOutput("abortGoErr", cfg_err, 0);
    checkOutput("abortGoBeats", beat_cnt, lastBeats);
  endtask

  task automatic resetMidDwell();
    go        = 1'b1;
    cfg_full  = 1'b0;
    cfg_start = W'(0);
    cfg_stop  = W'(10);
    cfg_step  = W'(1);
    cfg_dwell = DW'(5);
    out_ready = 1'b1;
    @(negedge clk);
    go = 1'b0;
    checkOutput("rstDriveValid", out_valid, 1);
    @(negedge clk);
    checkOutput("rstDwellValid", out_valid, 0);
    checkOutput("rstDwellBusy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkIdle("rstMid");
    checkOutput("rstMidData", out_data, 0);
    checkOutput("rstMidErr", cfg_err, 0);
    checkOutput("rstMidBeats", beat_cnt, 0);
    lastBeats = 0;
    @(negedge clk);
    checkIdle("rstMidHold");
  endtask

  initial begin
    int s, e, st, total, ab;
    rst_n     = 1'b0;
    go        = 1'b0;
    abort     = 1'b0;
    cfg_full  = 1'b0;
    cfg_start = '0;
    cfg_stop  = '0;
    cfg_step  = '0;
    cfg_dwell = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkIdle("reset");
    checkOutput("resetData", out_data, 0);
    checkOutput("resetErr", cfg_err, 0);
    checkOutput("resetBeats", beat_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b0, 3, 20, 5, 0, 100, -1, 1'b0);
    applyStimulus(1'b1, 0, 0, 0, 2, 100, -1, 1'b0);
    applyStimulus(1'b0, 250, 255, 4, 0, 100, -1, 1'b0);
    readyPat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    applyStimulus(1'b0, 0, 2, 1, 0, 100, -1, 1'b0);
    badGo(3, 10, 0);
    badGo(9, 4, 1);
    abortWithGo(1'b1);
    abortWithGo(1'b0);
    applyStimulus(1'b0, 0, 10, 1, 0, 100, 2, 1'b1);
    abortWithGo(1'b1);
    resetMidDwell();

    for (int i = 0; i < 25; i++) begin
      s     = $urandom_range(0, 255);
      e     = $urandom_range(s, 255);
      st    = $urandom_range(1, 64);
      total = (e - s) / st + 1;
      ab    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, total - 1) : -1;
      applyStimulus(1'b0, s, e, st, $urandom_range(0, 3), $urandom_range(50, 100), ab, 1'b1);
      if ($urandom_range(0, 3) == 0) badGo($urandom_range(10, 255), $urandom_range(0, 9), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
